// File: rtl/avalon_mem_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_mem_arbiter
//
// Two-master Avalon-MM arbiter in front of the single RAM slave. m0 is the CPU
// bus master, m1 is the instruction-load/debug master. One master owns the
// slave at a time. Its transfer is forwarded combinationally. The other master
// is held off with waitrequest.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin. On a tie, the master that did
//                                    not complete the last transfer wins.
//                       undefined -> fixed priority. m1 always beats m0.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   m0_*/m1_* address, read, write,  master-side request inputs
//     writedata, byteenable
//   m0_waitrequest, m1_waitrequest   per-master stall
//   m0_readdata, m1_readdata         broadcast of s_readdata
//   s_address, s_writedata,          slave-side request, muxed from the owner
//     s_byteenable, s_read, s_write
//   s_waitrequest, s_readdata        slave-side response
//   grant                            one-hot owner (01 = m0, 10 = m1, 00 = idle)
// -----------------------------------------------------------------------------
// state   | meaning
// --------+-------------------------------------------------------------------
// IDLE    | nobody owns the slave; strobes low; arbitrate pending requests
// G0      | m0 owns the slave; leave on completion or when m0 drops its request
// G1      | m1 owns the slave; leave on completion or when m1 drops its request
// -----------------------------------------------------------------------------
module avalon_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,

    output logic [1:0]            grant
);

    // The encoding doubles as the one-hot grant vector.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_G0   = 2'b01;
    localparam logic [1:0] ST_G1   = 2'b10;

    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last;
    logic       last_nxt;

    logic       m0_req;
    logic       m1_req;
    logic       pick_m1;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    // pick_m1 only matters while IDLE with at least one request pending.
`ifdef ARB_ROUND_ROBIN_EN
    // A lone requester wins. On a tie, m1 wins only if m0 completed last.
    assign pick_m1 = m1_req & (~m0_req | (last == LAST_M0));
`else
    // Fixed priority. The loader always wins. last is tracked but not consulted.
    assign pick_m1 = m1_req;
`endif

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (pick_m1) begin
                    state_nxt = ST_G1;
                end else if (m0_req) begin
                    state_nxt = ST_G0;
                end
            end
            ST_G0: begin
                if (!m0_req) begin
                    // Abandoned transfer: release the slave, keep fairness history.
                    state_nxt = ST_IDLE;
                end else if (!s_waitrequest) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = LAST_M0;
                end
            end
            ST_G1: begin
                if (!m1_req) begin
                    state_nxt = ST_IDLE;
                end else if (!s_waitrequest) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = LAST_M1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            last  <= LAST_M1;   // m0 takes the first round-robin tie
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // The slave side is muxed from state. A reset therefore drops the strobes
    // and the grant as soon as reset_n falls, without waiting for a clock edge.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            ST_G0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
            end
            ST_G1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
            end
        endcase
    end

    assign grant       = state;
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
module tb_avalon_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        clk;
    logic        reset_n;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    avalon_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM slave stand-in (64 words) ----------------
    logic        mem_init;
    logic [31:0] slv_mem [0:63];
    logic [31:0] ref_mem [0:63];

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h2403F00F;
        return {16'hA5A5, 16'(i)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) slv_mem[i] <= init_word(i);
        end else if (s_write && !s_waitrequest) begin
            slv_mem[s_address[7:2]] <= merge(slv_mem[s_address[7:2]], s_writedata, s_byteenable);
        end
    end

    assign s_readdata = slv_mem[s_address[7:2]];

    // ---------------- reference arbitration model ----------------
    int mdl_owner;   // -1 idle, 0 = m0, 1 = m1
    int mdl_last;    // master that completed the most recent transfer

    function automatic int arb_pick(input bit r0, input bit r1, input int lst);
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef ARB_ROUND_ROBIN_EN
        return (lst == 1) ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    // Random-test master state.
    bit          act [2];
    bit          is_wr [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_be [2];

    task automatic drive_masters();
        m0_read = act[0] && !is_wr[0];  m0_write = act[0] && is_wr[0];
        m1_read = act[1] && !is_wr[1];  m1_write = act[1] && is_wr[1];
        m0_address = r_addr[0]; m0_writedata = r_wdata[0]; m0_byteenable = r_be[0];
        m1_address = r_addr[1]; m1_writedata = r_wdata[1]; m1_byteenable = r_be[1];
    endtask

    // Advance the model across one rising edge; returns which master completed.
    task automatic model_edge(output int done_m);
        done_m = -1;
        if (mdl_owner == -1) begin
            mdl_owner = arb_pick(act[0], act[1], mdl_last);
        end else if (!act[mdl_owner]) begin
            mdl_owner = -1;
        end else if (!s_waitrequest) begin
            if (is_wr[mdl_owner])
                ref_mem[r_addr[mdl_owner][7:2]] = merge(ref_mem[r_addr[mdl_owner][7:2]],
                                                        r_wdata[mdl_owner], r_be[mdl_owner]);
            done_m    = mdl_owner;
            mdl_last  = mdl_owner;
            mdl_owner = -1;
        end
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        mem_init = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mem_init = 1'b0;
        mdl_owner = -1;
        mdl_last  = 1;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; is_wr[i] = 0; r_addr[i] = '0; r_wdata[i] = '0; r_be[i] = '0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n  = 1'b0;
        mem_init = 1'b1;
        clear_inputs();
        m0_read = 1'b1; m0_address = 32'h4; m1_write = 1'b1; m1_address = 32'h8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL reset_s_read: got %b expected 0", s_read); end
        checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL reset_s_write: got %b expected 0", s_write); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m0_wait: got %b expected 1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m1_wait: got %b expected 1", m1_waitrequest); end
        checks++; if (s_address !== 32'h0) begin errors++; $display("FAIL reset_s_address: got %h expected 0", s_address); end
        @(posedge clk); #1;
        clear_inputs();
        reset_n  = 1'b1;
        mem_init = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL idle_no_req_grant: got %b expected 00", grant); end
    endtask

    task automatic test_single_read();
        do_reset();
        m0_read = 1'b1; m0_address = 32'h4; s_waitrequest = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_cycle0_grant: got %b expected 00", grant); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rd_cycle0_wait: got %b expected 1", m0_waitrequest); end
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_cycle1_grant: got %b expected 01", grant); end
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_cycle1_wait: got %b expected 0", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rd_other_wait: got %b expected 1", m1_waitrequest); end
        checks++; if (s_read !== 1'b1 || s_address !== 32'h4) begin errors++; $display("FAIL rd_slave_req: got read=%b addr=%h expected 1/00000004", s_read, s_address); end
        checks++; if (m0_readdata !== 32'h2403F00F) begin errors++; $display("FAIL rd_data: got %h expected 2403f00f", m0_readdata); end
        checks++; if (m1_readdata !== 32'h2403F00F) begin errors++; $display("FAIL rd_broadcast: got %h expected 2403f00f", m1_readdata); end
        @(posedge clk); #1;
        m0_read = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || s_read !== 1'b0) begin errors++; $display("FAIL rd_back_idle: got grant=%b read=%b expected 00/0", grant, s_read); end
    endtask

    task automatic test_write_wait();
        int waits;
        do_reset();
        waits = 0;
        m1_write = 1'b1; m1_address = 32'h10; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
        s_waitrequest = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m1_waitrequest) waits++;
            if (c >= 1) begin
                checks++;
                if (grant !== 2'b10 || s_write !== 1'b1 || s_address !== 32'h10) begin
                    errors++;
                    $display("FAIL wr_hold c%0d: got grant=%b write=%b addr=%h expected 10/1/00000010", c, grant, s_write, s_address);
                end
            end
            @(posedge clk); #1;
            if (c == 3) s_waitrequest = 1'b0;
        end
        m1_write = 1'b0;
        checks++; if (waits != 4) begin errors++; $display("FAIL wr_wait_cycles: got %0d expected 4", waits); end
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wr_back_idle: got %b expected 00", grant); end
        @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 32'h10;
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== 2'b01 || m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_readback: got grant=%b data=%h expected 01/deadbeef", grant, m0_readdata); end
        @(posedge clk); #1;
        m0_read = 1'b0;
    endtask

    task automatic test_tie();
        logic [1:0] exp_g [8];
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`else
        exp_g = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
`endif
        do_reset();
        m0_read = 1'b1; m0_address = 32'h20;
        m1_read = 1'b1; m1_address = 32'h24;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== exp_g[c]) begin errors++; $display("FAIL tie_grant c%0d: got %b expected %b", c, grant, exp_g[c]); end
            @(posedge clk); #1;
        end
        m1_read = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_m0_after_m1_drop: got %b expected 01", grant); end
        @(posedge clk); #1;
        m0_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_read = 1'b1; m0_address = 32'h8; s_waitrequest = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== 2'b01 || s_read !== 1'b1) begin errors++; $display("FAIL mid_pre: got grant=%b read=%b expected 01/1", grant, s_read); end
        reset_n = 1'b0;
        #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL mid_s_read: got %b expected 0", s_read); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_grant: got %b expected 00", grant); end
        checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_wait: got %b%b expected 11", m0_waitrequest, m1_waitrequest); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        s_waitrequest = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_release_idle: got %b expected 00", grant); end
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== 2'b01 || m0_waitrequest !== 1'b0 || m0_readdata !== init_word(2)) begin
            errors++; $display("FAIL mid_reissue: got grant=%b wait=%b data=%h expected 01/0/%h", grant, m0_waitrequest, m0_readdata, init_word(2));
        end
        @(posedge clk); #1;
        m0_read = 1'b0;
    endtask

    task automatic test_abandon();
        logic [1:0] exp_tie;
`ifdef ARB_ROUND_ROBIN_EN
        exp_tie = 2'b01;
`else
        exp_tie = 2'b10;
`endif
        do_reset();
        m1_read = 1'b1; m1_address = 32'h30;
        repeat (2) @(posedge clk);
        #1;
        m1_read = 1'b0;
        m0_read = 1'b1; m0_address = 32'h34; s_waitrequest = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ab_granted: got %b expected 01", grant); end
        @(posedge clk); #1;
        m0_read = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b01 || s_read !== 1'b0) begin errors++; $display("FAIL ab_dropped: got grant=%b read=%b expected 01/0", grant, s_read); end
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ab_idle: got %b expected 00", grant); end
        @(posedge clk); #1;
        m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (grant !== exp_tie) begin errors++; $display("FAIL ab_next_tie: got %b expected %b", grant, exp_tie); end
        @(posedge clk); #1;
        m0_read = 1'b0; m1_read = 1'b0;
    endtask

    task automatic test_random();
        int done_m;
        logic [1:0]  e_grant;
        logic        e_rd, e_wr, e_w0, e_w1;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        do_reset();
        drive_masters();
        s_waitrequest = ($urandom_range(0, 2) == 0);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            e_grant = (mdl_owner == 0) ? 2'b01 : (mdl_owner == 1) ? 2'b10 : 2'b00;
            e_w0 = (mdl_owner == 0) ? s_waitrequest : 1'b1;
            e_w1 = (mdl_owner == 1) ? s_waitrequest : 1'b1;
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
            if (mdl_owner >= 0) begin
                e_rd = act[mdl_owner] && !is_wr[mdl_owner];
                e_wr = act[mdl_owner] && is_wr[mdl_owner];
                e_addr = r_addr[mdl_owner]; e_wd = r_wdata[mdl_owner]; e_be = r_be[mdl_owner];
            end
            checks++; if (grant !== e_grant) begin errors++; $display("FAIL rnd_grant cyc%0d: got %b expected %b", cyc, grant, e_grant); end
            checks++; if ({m0_waitrequest, m1_waitrequest} !== {e_w0, e_w1}) begin
                errors++; $display("FAIL rnd_wait cyc%0d: got %b%b expected %b%b", cyc, m0_waitrequest, m1_waitrequest, e_w0, e_w1);
            end
            checks++; if ({s_read, s_write, s_address, s_writedata, s_byteenable} !== {e_rd, e_wr, e_addr, e_wd, e_be}) begin
                errors++; $display("FAIL rnd_slave cyc%0d: got r=%b w=%b a=%h d=%h be=%h expected r=%b w=%b a=%h d=%h be=%h",
                                   cyc, s_read, s_write, s_address, s_writedata, s_byteenable, e_rd, e_wr, e_addr, e_wd, e_be);
            end
            if (mdl_owner >= 0 && e_rd && !s_waitrequest) begin
                checks++;
                if (((mdl_owner == 0) ? m0_readdata : m1_readdata) !== ref_mem[e_addr[7:2]]) begin
                    errors++; $display("FAIL rnd_rdata cyc%0d: got %h expected %h", cyc,
                                       (mdl_owner == 0) ? m0_readdata : m1_readdata, ref_mem[e_addr[7:2]]);
                end
            end
            @(posedge clk);
            model_edge(done_m);
            if (done_m >= 0) act[done_m] = 0;
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && $urandom_range(0, 1) == 1) begin
                    act[i]     = 1;
                    is_wr[i]   = ($urandom_range(0, 1) == 1);
                    r_addr[i]  = 32'($urandom_range(0, 15)) << 2;
                    r_wdata[i] = $urandom;
                    r_be[i]    = 4'($urandom_range(1, 15));
                end
            end
            #1;
            drive_masters();
            s_waitrequest = ($urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 2; i++) act[i] = 0;
        drive_masters();
    endtask

    initial begin
        reset_n  = 1'b0;
        mem_init = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_wait();
        test_tie();
        test_reset_mid();
        test_abandon();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
